// File: rtl/nanov_mul_seq.sv
// nanov_mul_seq: sequencer for the serial 32x32->32 low-half multiplier.
// Clears the accumulator, streams b bits, drains the product serially.
module nanov_mul_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        mul_rstn,
  output logic [31:0] mul_a,
  output logic        mul_b,
  output logic        mul_read_out,
  input  logic        mul_d
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MUL,
    S_READ,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_valid;
  logic        w_mul_last;
  logic        w_read_last;

  // MUL ends on the last set b bit (early exit) or after 32 cycles
  assign w_mul_last  = EARLY_EXIT ? (r_b[31:1] == 31'd0)
                                  : (r_cnt == 5'd31);
  assign w_read_last = (r_cnt == 5'd31);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; DONE only exits once the valid flag is up
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_MUL;
      S_MUL:   if (w_mul_last) w_next = S_READ;
      S_READ:  if (w_read_last) w_next = S_DONE;
      S_DONE:  if (r_valid && result_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shifting, counter, serial result capture, valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_cnt <= '0;
          end
        end
        S_MUL: begin
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= w_mul_last ? 5'd0 : r_cnt + 5'd1;
        end
        S_READ: begin
          r_result <= {mul_d, r_result[31:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        S_DONE: begin
          if (!r_valid)          r_valid <= 1'b1;
          else if (result_ready) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign result_valid = r_valid;
  assign mul_rstn     = ~rst & (r_state != S_CLEAR);
  assign mul_a        = r_a;
  assign mul_b        = (r_state == S_MUL) & r_b[0];
  assign mul_read_out = (r_state == S_READ);

endmodule

// File: tb/tb_nanov_mul_seq.sv
// tb_nanov_mul_seq: randomized self-checking bench for nanov_mul_seq.
// Includes a behavioural serial accumulator driving mul_d.
module tb_nanov_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        result_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  logic        busy1, v1, rstn1, b1, ro1, d1;
  logic [31:0] res1, a1, acc1;
  logic        busy0, v0, rstn0, b0, ro0, d0;
  logic [31:0] res0, a0, acc0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nanov_mul_seq #(.EARLY_EXIT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start & ~sel),
    .op_a(op_a), .op_b(op_b), .busy(busy1),
    .result(res1), .result_valid(v1),
    .result_ready(result_ready & ~sel),
    .mul_rstn(rstn1), .mul_a(a1), .mul_b(b1),
    .mul_read_out(ro1), .mul_d(d1)
  );

  nanov_mul_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start & sel),
    .op_a(op_a), .op_b(op_b), .busy(busy0),
    .result(res0), .result_valid(v0),
    .result_ready(result_ready & sel),
    .mul_rstn(rstn0), .mul_a(a0), .mul_b(b0),
    .mul_read_out(ro0), .mul_d(d0)
  );

  // serial multiplier datapath models
  always_ff @(posedge clk) begin
    if (!rstn1)   acc1 <= '0;
    else if (ro1) acc1 <= acc1 >> 1;
    else if (b1)  acc1 <= acc1 + a1;
  end
  always_ff @(posedge clk) begin
    if (!rstn0)   acc0 <= '0;
    else if (ro0) acc0 <= acc0 >> 1;
    else if (b0)  acc0 <= acc0 + a0;
  end
  assign d1 = acc1[0];
  assign d0 = acc0[0];

  logic        m_busy, m_valid, m_rstn, m_b, m_ro;
  logic [31:0] m_res, m_a;
  assign m_busy  = sel ? busy0 : busy1;
  assign m_valid = sel ? v0 : v1;
  assign m_rstn  = sel ? rstn0 : rstn1;
  assign m_b     = sel ? b0 : b1;
  assign m_ro    = sel ? ro0 : ro1;
  assign m_res   = sel ? res0 : res1;
  assign m_a     = sel ? a0 : a1;

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int mul_cycles(input logic [31:0] v);
    return (bitlen(v) == 0) ? 1 : bitlen(v);
  endfunction

  // lat = edges after the accepting edge until valid is seen
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output int nclr, output int nmul,
                        output int nread, output int nbones,
                        output bit to);
    bit seen = 0;
    nclr = 0; nmul = 0; nread = 0; nbones = 0;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1; result_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!m_valid && lat < 200) begin
      if (!m_rstn) nclr++;
      else if (m_ro) begin nread++; seen = 1; end
      else if (nclr > 0 && !seen) begin
        nmul++;
        if (m_b) nbones++;
      end
      @(negedge clk);
      lat++;
    end
    to = !m_valid;
    res = m_res;
  endtask

  task automatic finish_hs();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || v1 !== 1'b0 || res1 !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_out busy=%b valid=%b res=%h need 0/0/0",
               busy1, v1, res1);
    end
    n_cmp++;
    if (rstn1 !== 1'b0 || b1 !== 1'b0 || ro1 !== 1'b0 || a1 !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mul rstn=%b b=%b ro=%b a=%h need 0/0/0/0",
               rstn1, b1, ro1, a1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rstn1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset rstn=%b busy=%b need 1/0", rstn1, busy1);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    int lat, nc, nm, nr, nb;
    bit to;
    run_op(32'd3, 32'd5, r, lat, nc, nm, nr, nb, to);
    n_cmp++;
    if (to || r !== 32'd15) begin
      n_bad++;
      $display("FAIL basic_res got %h need 0000000f (to=%0d)", r, to);
    end
    n_cmp++;
    if (lat != 37 || nm != 3 || nc != 1 || nr != 32) begin
      n_bad++;
      $display("FAIL basic_timing lat=%0d mul=%0d clr=%0d rd=%0d need 37/3/1/32",
               lat, nm, nc, nr);
    end
    finish_hs();
    n_cmp++;
    if (busy1 !== 1'b0 || v1 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle busy=%b valid=%b need 0/0", busy1, v1);
    end
  endtask

  task automatic test_full();
    logic [31:0] r1, r0;
    int l1, l0, nc, nm1, nm0, nr, nb;
    bit to;
    sel = 1'b0;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, r1, l1, nc, nm1, nr, nb, to);
    n_cmp++;
    if (to || r1 !== 32'h1 || nm1 != 32 || l1 != 66 || nb != 32) begin
      n_bad++;
      $display("FAIL full_ee1 res=%h lat=%0d mul=%0d ones=%0d need 1/66/32/32",
               r1, l1, nm1, nb);
    end
    finish_hs();
    sel = 1'b1;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, r0, l0, nc, nm0, nr, nb, to);
    n_cmp++;
    if (to || r0 !== 32'h1 || nm0 != 32 || l0 != 66) begin
      n_bad++;
      $display("FAIL full_ee0 res=%h lat=%0d mul=%0d need 1/66/32",
               r0, l0, nm0);
    end
    finish_hs();
    sel = 1'b0;
  endtask

  task automatic test_zero_and_msb();
    logic [31:0] r;
    int lat, nc, nm, nr, nb;
    bit to;
    run_op(32'h12345678, 32'd0, r, lat, nc, nm, nr, nb, to);
    n_cmp++;
    if (to || r !== 32'd0 || nm != 1 || nb != 0 || lat != 35) begin
      n_bad++;
      $display("FAIL zero_b res=%h mul=%0d ones=%0d lat=%0d need 0/1/0/35",
               r, nm, nb, lat);
    end
    finish_hs();
    run_op(32'd1, 32'h80000000, r, lat, nc, nm, nr, nb, to);
    n_cmp++;
    if (to || r !== 32'h80000000 || nm != 32 || lat != 66) begin
      n_bad++;
      $display("FAIL msb_b res=%h mul=%0d lat=%0d need 80000000/32/66",
               r, nm, lat);
    end
    finish_hs();
  endtask

  task automatic test_backpressure();
    logic [31:0] r, exp;
    int lat, nc, nm, nr, nb;
    bit to;
    exp = 32'h1234 * 32'h55;
    run_op(32'h1234, 32'h55, r, lat, nc, nm, nr, nb, to);
    n_cmp++;
    if (to || r !== exp) begin
      n_bad++;
      $display("FAIL bp_res got %h need %h", r, exp);
    end
    for (int i = 0; i < 10; i++) begin
      op_a = $urandom; op_b = $urandom;
      start = i[0];
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b1 || res1 !== exp) begin
        n_bad++;
        $display("FAIL bp_hold%0d valid=%b res=%h need 1/%h", i, v1, res1, exp);
      end
    end
    start = 1'b0;
    finish_hs();
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || v1 !== 1'b0 || res1 !== exp) begin
      n_bad++;
      $display("FAIL bp_release busy=%b valid=%b res=%h need 0/0/%h",
               busy1, v1, res1, exp);
    end
    run_op(32'd7, 32'd6, r, lat, nc, nm, nr, nb, to);
    n_cmp++;
    if (to || r !== 32'd42) begin
      n_bad++;
      $display("FAIL bp_next got %h need 0000002a", r);
    end
    finish_hs();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat, nc, nm, nr, nb, w;
    bit to;
    @(negedge clk);
    op_a = 32'hDEADBEEF; op_b = 32'h00013579; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!ro1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!ro1) begin
      n_bad++;
      $display("FAIL rmid_read_wait read_out=%b need 1", ro1);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy1 !== 1'b0 || v1 !== 1'b0 || rstn1 !== 1'b0 ||
        ro1 !== 1'b0 || res1 !== 32'd0) begin
      n_bad++;
      $display("FAIL rmid_out busy=%b valid=%b rstn=%b ro=%b res=%h need 0/0/0/0/0",
               busy1, v1, rstn1, ro1, res1);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd9, 32'd9, r, lat, nc, nm, nr, nb, to);
    n_cmp++;
    if (to || r !== 32'd81 || lat != 38) begin
      n_bad++;
      $display("FAIL rmid_after res=%h lat=%0d need 00000051/38", r, lat);
    end
    finish_hs();
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, exp;
    int lat, nc, nm, nr, nb;
    bit to;
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) b = b >> $urandom_range(0, 31);
      if (i % 50 == 7) b = 32'd0;
      exp = a * b;
      run_op(a, b, r, lat, nc, nm, nr, nb, to);
      n_cmp++;
      if (to || r !== exp) begin
        n_bad++;
        $display("FAIL rnd_res%0d %h*%h got %h need %h", i, a, b, r, exp);
      end
      n_cmp++;
      if (nc != 1 || nr != 32 || lat != 34 + mul_cycles(b)) begin
        n_bad++;
        $display("FAIL rnd_seq%0d clr=%0d rd=%0d lat=%0d need 1/32/%0d",
                 i, nc, nr, lat, 34 + mul_cycles(b));
      end
      finish_hs();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_zero_and_msb();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
